// File: rtl/rr_decode_arbiter.sv
// Round-robin owner sequencer for a shared 3-to-8 decoder with bounded grant tenure.
// Optional macro ARB_LOCK_EN adds a lock input that suppresses tenure expiry.
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       req,
   input  logic             done,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic [7:0]       gnt,
   output logic [2:0]       gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

   logic [1:0]       state;
   logic [2:0]       ptr;
   logic [CNT_W-1:0] cnt;

   logic [3:0]       arb;
   logic             lock_on;
   logic             at_last;
   logic             owner_req;
   logic             expire;
   logic             release_now;

   // {found, index} of the first set request after p, wrapping modulo 8;
   // scanning from the far end lets the nearest hit overwrite the rest.
   function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 8; i >= 1; i--) begin
         idx = p + 3'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

`ifdef ARB_LOCK_EN
   assign lock_on = lock;
`else
   assign lock_on = 1'b0;
`endif

   always_comb begin
      arb         = pick(req, ptr);
      at_last     = (cnt == LAST);
      owner_req   = req[gnt_idx];
      expire      = at_last & ~lock_on;
      release_now = done | ~owner_req | expire;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= 3'd7;
         cnt       <= '0;
         gnt       <= 8'd0;
         gnt_idx   <= 3'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            // GAP arbitrates too, so consecutive owners see exactly one idle cycle
            S_IDLE, S_GAP: begin
               if (arb[3]) begin
                  gnt_idx   <= arb[2:0];
                  gnt       <= 8'd1 << arb[2:0];
                  gnt_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= S_GRANT;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_GRANT: begin
               if (release_now) begin
                  gnt_valid <= 1'b0;
                  gnt       <= 8'd0;
                  ptr       <= gnt_idx;
                  timeout   <= expire & ~done & owner_req;
                  state     <= S_GAP;
               end else if (!at_last) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (lock scenario under ARB_LOCK_EN).
module tb_rr_decode_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic       lock;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   int total;
   int bad;

   rr_decode_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req  = 8'd0;
      done = 1'b0;
      lock = 1'b0;
      rst  = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (gnt !== 8'd0) begin bad++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
      total++; if (gnt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
      total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
   endtask

   task automatic test_single_done();
      do_reset();
      req = 8'b0000_0001;
      step();
      total++; if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
         bad++; $display("FAIL single_grant got gnt=%h idx=%0d v=%b exp gnt=01 idx=0 v=1", gnt, gnt_idx, gnt_valid); end
      step();
      total++; if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
         bad++; $display("FAIL single_hold got gnt=%h v=%b exp gnt=01 v=1", gnt, gnt_valid); end
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 8'd0;
      total++; if (gnt !== 8'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         bad++; $display("FAIL single_release got gnt=%h v=%b to=%b exp gnt=00 v=0 to=0", gnt, gnt_valid, timeout); end
      step();
      total++; if (gnt !== 8'd0 || gnt_valid !== 1'b0) begin
         bad++; $display("FAIL single_idle got gnt=%h v=%b exp gnt=00 v=0", gnt, gnt_valid); end
   endtask

   task automatic test_all_ones();
      logic [2:0] e;
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         e = 3'(k % 8);
         step();
         total++; if (gnt_valid !== 1'b1 || gnt_idx !== e || gnt !== (8'd1 << e) || timeout !== 1'b0) begin
            bad++; $display("FAIL rr_grant%0d got idx=%0d gnt=%h v=%b to=%b exp idx=%0d", k, gnt_idx, gnt, gnt_valid, timeout, e); end
         done = 1'b1;
         step();
         done = 1'b0;
         total++; if (gnt_valid !== 1'b0 || gnt !== 8'd0 || timeout !== 1'b0) begin
            bad++; $display("FAIL rr_gap%0d got gnt=%h v=%b to=%b exp gnt=00 v=0 to=0", k, gnt, gnt_valid, timeout); end
      end
      req = 8'd0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 8'b0010_0000;
      for (int c = 0; c < 4; c++) begin
         step();
         total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || gnt !== 8'h20 || timeout !== 1'b0) begin
            bad++; $display("FAIL to_hold%0d got idx=%0d gnt=%h v=%b to=%b exp idx=5 gnt=20 v=1 to=0", c, gnt_idx, gnt, gnt_valid, timeout); end
      end
      step();
      total++; if (gnt_valid !== 1'b0 || gnt !== 8'd0 || timeout !== 1'b1) begin
         bad++; $display("FAIL to_release got gnt=%h v=%b to=%b exp gnt=00 v=0 to=1", gnt, gnt_valid, timeout); end
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || timeout !== 1'b0) begin
         bad++; $display("FAIL to_regrant got idx=%0d v=%b to=%b exp idx=5 v=1 to=0", gnt_idx, gnt_valid, timeout); end
      req = 8'd0;
   endtask

   task automatic test_req_drop();
      do_reset();
      req = 8'b1000_1000;
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3 || gnt !== 8'h08) begin
         bad++; $display("FAIL drop_owner got idx=%0d gnt=%h v=%b exp idx=3 gnt=08 v=1", gnt_idx, gnt, gnt_valid); end
      // bit 0 added: with ptr=3 the scan reaches 7 before 0
      req = 8'b1000_0001;
      step();
      total++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         bad++; $display("FAIL drop_release got v=%b to=%b exp v=0 to=0", gnt_valid, timeout); end
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7 || gnt !== 8'h80) begin
         bad++; $display("FAIL drop_next got idx=%0d gnt=%h v=%b exp idx=7 gnt=80 v=1", gnt_idx, gnt, gnt_valid); end
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt !== 8'h01) begin
         bad++; $display("FAIL drop_wrap got idx=%0d gnt=%h v=%b exp idx=0 gnt=01 v=1", gnt_idx, gnt, gnt_valid); end
      req = 8'd0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 8'b0100_0000;
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
         bad++; $display("FAIL mid_owner got idx=%0d v=%b exp idx=6 v=1", gnt_idx, gnt_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (gnt !== 8'd0 || gnt_valid !== 1'b0) begin
         bad++; $display("FAIL mid_async got gnt=%h v=%b exp gnt=00 v=0", gnt, gnt_valid); end
      req = 8'b0100_0001;
      step();
      rst = 1'b0;
      step();
      total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt !== 8'h01) begin
         bad++; $display("FAIL mid_after got idx=%0d gnt=%h v=%b exp idx=0 gnt=01 v=1", gnt_idx, gnt, gnt_valid); end
      req = 8'd0;
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      do_reset();
      lock = 1'b1;
      req  = 8'b0000_0100;
      step();
      for (int c = 0; c < 10; c++) begin
         total++; if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || timeout !== 1'b0) begin
            bad++; $display("FAIL lock_hold%0d got idx=%0d v=%b to=%b exp idx=2 v=1 to=0", c, gnt_idx, gnt_valid, timeout); end
         if (c == 9) done = 1'b1;
         step();
      end
      done = 1'b0;
      total++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
         bad++; $display("FAIL lock_release got v=%b to=%b exp v=0 to=0", gnt_valid, timeout); end
      lock = 1'b0;
      req  = 8'd0;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 8'd0;
      done  = 1'b0;
      lock  = 1'b0;
      test_reset();
      test_single_done();
      test_all_ones();
      test_timeout();
      test_req_drop();
      test_reset_mid();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 decode resource among 8 requesters.
- Selects one requester, holds the 3-bit grant index stable for the grant tenure, and drives the one-hot decoded grant vector.
- Sits between the requester bank and the shared decoder: sequences who owns the decoder and for how long.
- Enforces a maximum tenure so no requester starves the others.

Parameters:
- MAX_HOLD, 4, maximum cycles a grant may be held before forced release (legal range 1..15).
- CNT_W, 4, width of the tenure counter; must hold MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; req[i] high means requester i wants the decoder.
- done  input  1  current owner finished; releases the grant.
- gnt  output  8  one-hot grant (decoded gnt_idx); all zero when no grant.
- gnt_idx  output  3  binary index of the current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- All outputs are registered. gnt is decoded from registered gnt_idx/gnt_valid, with no combinational path from req to gnt.
- Reset (async assert, sync-safe deassert):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - Priority pointer ptr=7, so requester 0 has top priority after reset. State=IDLE, tenure counter=0.
- FSM has three states: IDLE, GRANT, GAP.
  - IDLE: at any edge with req!=0, pick the first set bit searching ptr+1, ptr+2, ... modulo 8. Load gnt_idx, set gnt_valid=1, go to GRANT, counter=0. Grant is visible 1 cycle after req is sampled. With req=0, stay in IDLE.
  - GRANT: counter increments each cycle. Release when any of the following holds at an edge:
    - done=1
    - req[gnt_idx]=0
    - counter==MAX_HOLD-1
  - On release: gnt_valid=0, gnt=0, ptr=gnt_idx, go to GAP.
  - If release is due only to counter expiry (done=0 and req[gnt_idx]=1), pulse timeout=1 for exactly that cycle.
  - GAP: one idle cycle with gnt=0, so no two owners are granted on adjacent cycles. Then go to IDLE. Arbitration may occur on the GAP->IDLE edge, so back-to-back grants have a 1-cycle bubble.
- Round-robin fairness: ptr updates only on release. The releasing owner becomes lowest priority.
- Simultaneous done and counter expiry: counts as a normal release, timeout=0.
- done while in IDLE or GAP is ignored.
- A single requester holding req continuously gets repeated MAX_HOLD-cycle grants separated by 1-cycle gaps, with timeout pulsing at each release.
- gnt_idx holds its last value when gnt_valid=0. Checkers must not compare it then.
- Reset mid-grant: outputs clear immediately (asynchronous), ptr returns to 7, and any in-flight tenure is discarded.
- Invariant: popcount(gnt) ≤ 1 on every cycle, and gnt==(1<<gnt_idx) whenever gnt_valid=1.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While in GRANT with lock=1, the MAX_HOLD expiry is suppressed and the counter saturates at MAX_HOLD-1. Release then occurs only on done or req drop, and timeout never asserts during a locked tenure. Lock sampled in IDLE or GAP has no effect.
- Not defined: no lock port; MAX_HOLD expiry always applies.

Test Plan:
- Reset then req=8'b0000_0001, done pulsed 2 cycles after grant -> gnt=8'b0000_0001 and gnt_idx=0 one cycle after req; gnt=0 the cycle after done; one GAP cycle.
- req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0, each separated by 1 gap cycle; timeout never asserts.
- req=8'b0010_0000 held, done=0, MAX_HOLD=4 -> gnt_idx=5 for exactly 4 cycles, timeout=1 on the release cycle, 1 gap, then regranted to 5.
- Owner 3 active, req=8'b1000_1000, drop req[3] -> release; next grant goes to 7 (not 3), and ptr=3 afterwards.
- Assert rst mid-tenure with gnt_idx=6 -> gnt=0 and gnt_valid=0 immediately; after deassert with req=8'b0100_0001, first grant goes to 0.
- ARB_LOCK_EN defined, lock=1, req[2] held 10 cycles, done at cycle 10 -> gnt_idx=2 for all 10 cycles, timeout=0; release on done.
